// File: rtl/dcm_pkg.sv
// Shared defaults and helpers for the dcm_multi clock-enable generator.
package dcm_pkg;

    localparam int DEF_HALF_MS_CONT = 5000000;
    localparam int DEF_SEL_W        = 3;

    // Fast-clock rises a channel spends in each level before toggling, minus one.
    function automatic int unsigned ch_tc(input int unsigned sel);
        return (32'd1 << sel) - 32'd1;
    endfunction

endpackage

// File: rtl/dcm_channel.sv
// One slow channel: rise-driven divider, deferred selector commit and rising tick.
// Optional macro DCM_UPD_ACK_EN adds a one-cycle commit acknowledge output.
module dcm_channel
    import dcm_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rise,
    input  logic             i_update,
    input  logic [SEL_W-1:0] i_prog,
    output logic             o_clk_2,
    output logic             o_tick,
    output logic [SEL_W-1:0] o_sel,
`ifdef DCM_UPD_ACK_EN
    output logic             o_upd_ack,
`endif
    output logic             o_pending
);

    localparam int CW = (1 << SEL_W) - 1;

    logic [CW-1:0]    r_cnt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_pend_sel;
    logic             r_pending;
    logic             r_clk_2;
    logic             r_tick;
`ifdef DCM_UPD_ACK_EN
    logic             r_ack;
`endif
    logic             w_tc;

    assign w_tc = (r_cnt == CW'(ch_tc(32'(r_sel))));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_sel      <= '0;
            r_pend_sel <= '0;
            r_pending  <= 1'b0;
            r_clk_2    <= 1'b0;
            r_tick     <= 1'b0;
`ifdef DCM_UPD_ACK_EN
            r_ack      <= 1'b0;
`endif
        end else begin
            r_tick <= 1'b0;
`ifdef DCM_UPD_ACK_EN
            r_ack  <= 1'b0;
`endif
            if (i_rise) begin
                if (w_tc) begin
                    r_cnt   <= '0;
                    r_clk_2 <= ~r_clk_2;
                    r_tick  <= ~r_clk_2;
                    if (r_pending) begin
                        r_sel     <= r_pend_sel;
                        r_pending <= 1'b0;
`ifdef DCM_UPD_ACK_EN
                        r_ack     <= 1'b1;
`endif
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            // A capture in the commit cycle wins over the clear: the new value stays pending.
            if (i_update) begin
                r_pend_sel <= i_prog;
                r_pending  <= 1'b1;
            end
        end
    end

    assign o_clk_2   = r_clk_2;
    assign o_tick    = r_tick;
    assign o_sel     = r_sel;
    assign o_pending = r_pending;
`ifdef DCM_UPD_ACK_EN
    assign o_upd_ack = r_ack;
`endif

endmodule

// File: rtl/dcm_multi.sv
// Clock-enable generator: fixed fast base divider plus NUM_CH programmable slow channels.
// Optional macro DCM_UPD_ACK_EN adds the upd_ack output.
module dcm_multi
    import dcm_pkg::*;
#(
    parameter int HALF_MS_CONT = DEF_HALF_MS_CONT,
    parameter int NUM_CH       = 2,
    parameter int SEL_W        = DEF_SEL_W
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       update,
    input  logic [NUM_CH*SEL_W-1:0] prog_in,
    output logic                    clk_1,
    output logic                    clk_1_tick,
    output logic [NUM_CH-1:0]       clk_2,
    output logic [NUM_CH-1:0]       clk_2_tick,
    output logic [NUM_CH*SEL_W-1:0] prog_out,
`ifdef DCM_UPD_ACK_EN
    output logic [NUM_CH-1:0]       upd_ack,
`endif
    output logic [NUM_CH-1:0]       pending
);

    localparam int CNT_W = $clog2(HALF_MS_CONT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_1;
    logic             r_clk_1_tick;
    logic             w_ht;
    logic             w_rise;

    assign w_ht   = (r_cnt == CNT_W'(HALF_MS_CONT - 1));
    assign w_rise = w_ht & ~r_clk_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_clk_1      <= 1'b0;
            r_clk_1_tick <= 1'b0;
        end else begin
            r_clk_1_tick <= w_rise;
            if (w_ht) begin
                r_cnt   <= '0;
                r_clk_1 <= ~r_clk_1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign clk_1      = r_clk_1;
    assign clk_1_tick = r_clk_1_tick;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dcm_channel #(.SEL_W(SEL_W)) u_ch (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_rise    (w_rise),
            .i_update  (update[g]),
            .i_prog    (prog_in[g*SEL_W +: SEL_W]),
            .o_clk_2   (clk_2[g]),
            .o_tick    (clk_2_tick[g]),
            .o_sel     (prog_out[g*SEL_W +: SEL_W]),
`ifdef DCM_UPD_ACK_EN
            .o_upd_ack (upd_ack[g]),
`endif
            .o_pending (pending[g])
        );
    end

endmodule

// File: doc/dcm_multi.md
Name: dcm_multi

Overview:
- Next-generation clock-enable generator for the 100 MHz system clock.
- One fixed fast base clock: 10 Hz at default parameters.
- NUM_CH independently programmable slow channels, each running at fast/2^(sel+1).
- Frequency changes are deferred to the channel's next toggle, so no truncated or glitched slow periods occur.
- Each channel also emits a single-cycle tick, so downstream logic stays in the clk domain.

Parameters:
- HALF_MS_CONT, 5000000: clk cycles per fast-clock half-period. Minimum legal value is 2.
- NUM_CH, 2: number of slow channels, 1..8.
- SEL_W, 3: width of each channel's frequency selector. Legal sel range is 0..2^SEL_W-1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- update  in  NUM_CH  per-channel request to load that channel's prog_in slice.
- prog_in  in  NUM_CH*SEL_W  requested selectors; channel i is bits [i*SEL_W +: SEL_W].
- clk_1  out  1  fast clock level, 50% duty.
- clk_1_tick  out  1  one-cycle pulse on each clk_1 rising transition.
- clk_2  out  NUM_CH  slow clock levels.
- clk_2_tick  out  NUM_CH  one-cycle pulse on each clk_2[i] rising transition.
- prog_out  out  NUM_CH*SEL_W  active (committed) selector per channel.
- pending  out  NUM_CH  high while an update is captured but not yet committed.

Behaviour:
- Reset: on posedge clk with rst=1, all counters, clk_1, clk_1_tick, clk_2, clk_2_tick, prog_out and pending go to 0; the pending-selector registers go to 0. Reset mid-period discards the period; no partial state survives.
- Base divider:
  - cnt runs 0..HALF_MS_CONT-1 and has width $clog2(HALF_MS_CONT).
  - half event ht = (cnt==HALF_MS_CONT-1). On ht: cnt<=0 and clk_1 toggles.
  - Rise event rise = ht & ~clk_1.
  - clk_1_tick is registered: high in the cycle in which clk_1 first reads 1.
- Channel i:
  - Counter ch_cnt[i] is 2^SEL_W-1 bits wide and advances only on rise.
  - On rise with ch_cnt[i]==2^sel_i-1: ch_cnt[i]<=0, clk_2[i] toggles, and the commit point occurs.
  - Otherwise on rise: ch_cnt[i]++.
  - clk_2 half-period = 2^sel fast periods. clk_2_tick[i] is registered, aligned like clk_1_tick.
- Update handshake:
  - update[i]=1 captures the slice into pend_sel[i] and sets pending[i] the next cycle.
  - A repeated update before commit overwrites pend_sel[i] (last wins).
  - At the commit point with pending[i]=1, sel_i<=pend_sel[i], pending[i]<=0, and the new period starts from ch_cnt=0.
  - Update in the same cycle as a commit: the commit uses the previously stored pend_sel; the new value is captured and pending stays 1.
  - Update with a value equal to the active sel is legal and commits normally.
  - update is level-sampled every cycle; holding it high re-captures each cycle.
- Latency: prog_out changes exactly at the commit clock edge, never mid-period.
- Channels are fully independent; simultaneous updates on all channels are legal.

Optional Feature:
- Macro: DCM_UPD_ACK_EN.
- When defined: adds output upd_ack [NUM_CH], a one-cycle pulse in the cycle after channel i commits, reset to 0.
- When undefined: the port does not exist, and pending alone signals completion.

Decomposition:
- Package dcm_pkg holds:
  - localparams for the default HALF_MS_CONT and the default SEL_W;
  - a function returning the channel terminal count 2^sel-1.
- Natural sub-module dcm_channel covers one channel's counter, toggle, pending/commit and tick logic, instantiated NUM_CH times by generate.
- The base divider stays in the top level.

Test Plan:
All cases use HALF_MS_CONT=4 and NUM_CH=2, giving a clk_1 period of 8 cycles.
1. Release reset -> clk_1 first rises 4 cycles after rst deasserts; clk_1_tick pulses once every 8 cycles; all clk_2 low and prog_out=0 before the first rise.
2. Default sel=0 -> clk_2[0] period 16 cycles, 50% duty; clk_2_tick[0] every 16 cycles.
3. Pulse update[1] with sel 2 mid-period -> pending[1]=1 next cycle; prog_out unchanged until channel 1's next toggle; then period is 64 cycles and pending[1]=0.
4. Two updates (3 then 1) before commit -> only 1 is committed; one commit event, and upd_ack pulses once when DCM_UPD_ACK_EN is defined.
5. Update coinciding with a commit edge -> old pend_sel committed; new value held with pending=1 until the next toggle.
6. Assert rst mid-slow-period with pending set -> next cycle all outputs 0 and pending=0; restart timing identical to scenario 1.
